// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for a single SRAM-like bus. The fetch port (I) and
// the MEM-stage data port (D) share one bus with a single outstanding
// transaction. D normally wins; I is forced through after STARVE_LIMIT
// consecutive D grants. A flush cancels the response of an in-flight fetch.
module mem_bus_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_if_valid,
   output logic        o_if_ready,
   input  logic [31:0] i_if_addr,
   output logic        o_if_resp_valid,
   output logic [31:0] o_if_rdata,
   input  logic        i_if_cancel,
   input  logic        i_mem_valid,
   output logic        o_mem_ready,
   input  logic        i_mem_we,
   input  logic [3:0]  i_mem_wstrb,
   input  logic [31:0] i_mem_addr,
   input  logic [31:0] i_mem_wdata,
   output logic        o_mem_resp_valid,
   output logic [31:0] o_mem_rdata,
   output logic        o_bus_req,
   output logic        o_bus_wr,
   output logic [3:0]  o_bus_wstrb,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   input  logic        i_bus_addr_ok,
   input  logic        i_bus_data_ok,
   input  logic [31:0] i_bus_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } bus_cmd_t;

   localparam logic OWN_D = 1'b0;
   localparam logic OWN_I = 1'b1;

   state_t      state, state_nxt;
   bus_cmd_t    cmd_q;
   logic        owner_q;
   logic [3:0]  starve_cnt;
   logic        cancel_flag;
   logic [31:0] if_rdata_q, mem_rdata_q;

   logic if_req, forced_i, in_idle, grant_d, grant_i, done, if_resp, mem_resp;

   // Grant and completion decode. A cancelled fetch is never a candidate,
   // and readys are held low while reset is asserted so nothing is lost.
   always_comb begin
      if_req   = i_if_valid & ~i_if_cancel;
      forced_i = if_req & (starve_cnt >= 4'(STARVE_LIMIT));
      in_idle  = (state == IDLE) & rst;
      grant_d  = in_idle & i_mem_valid & ~forced_i;
      grant_i  = in_idle & if_req & (~i_mem_valid | forced_i);
      done     = i_bus_data_ok & (((state == REQ) & i_bus_addr_ok) | (state == WAIT));
      mem_resp = done & (owner_q == OWN_D);
      // A flush arriving in the data_ok cycle itself also drops the fetch.
      if_resp  = done & (owner_q == OWN_I) & ~cancel_flag & ~i_if_cancel;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic: addr_ok+data_ok together in REQ skips WAIT.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_d | grant_i) state_nxt = REQ;
         REQ:     if (i_bus_addr_ok) state_nxt = i_bus_data_ok ? IDLE : WAIT;
         WAIT:    if (i_bus_data_ok) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: bus command straight from registers, responses combinational.
   always_comb begin
      o_bus_req        = (state == REQ);
      o_bus_wr         = cmd_q.wr;
      o_bus_wstrb      = cmd_q.wstrb;
      o_bus_addr       = cmd_q.addr;
      o_bus_wdata      = cmd_q.wdata;
      o_mem_ready      = grant_d;
      o_if_ready       = grant_i;
      o_mem_resp_valid = mem_resp;
      o_if_resp_valid  = if_resp;
      o_mem_rdata      = mem_resp ? i_bus_rdata : mem_rdata_q;
      o_if_rdata       = if_resp  ? i_bus_rdata : if_rdata_q;
   end

   // Command latch, owner, starvation counter, cancel flag, held read data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_q       <= '0;
         owner_q     <= OWN_D;
         starve_cnt  <= '0;
         cancel_flag <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         if (grant_d) begin
            cmd_q   <= '{addr: i_mem_addr, wr: i_mem_we, wstrb: i_mem_wstrb, wdata: i_mem_wdata};
            owner_q <= OWN_D;
         end else if (grant_i) begin
            cmd_q   <= '{addr: i_if_addr, wr: 1'b0, wstrb: 4'h0, wdata: 32'h0};
            owner_q <= OWN_I;
         end

         if (grant_d && if_req) begin
            if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
         end else if (grant_i || (state == IDLE && !i_if_valid)) begin
            starve_cnt <= '0;
         end

         if (state_nxt == IDLE)
            cancel_flag <= 1'b0;
         else if (state != IDLE && owner_q == OWN_I && i_if_cancel)
            cancel_flag <= 1'b1;

         if (mem_resp) mem_rdata_q <= i_bus_rdata;
         if (if_resp)  if_rdata_q  <= i_bus_rdata;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Expected responses go into a
// scoreboard when the bus completion is driven; a negedge monitor pops
// them when the DUT pulses a response and flags any unexpected pulse.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0, rst = 1'b0;
   logic        i_if_valid = 0, i_if_cancel = 0, i_mem_valid = 0, i_mem_we = 0;
   logic [31:0] i_if_addr = 0, i_mem_addr = 0, i_mem_wdata = 0, i_bus_rdata = 0;
   logic [3:0]  i_mem_wstrb = 0;
   logic        i_bus_addr_ok = 0, i_bus_data_ok = 0;
   logic        o_if_ready, o_if_resp_valid, o_mem_ready, o_mem_resp_valid;
   logic        o_bus_req, o_bus_wr;
   logic [3:0]  o_bus_wstrb;
   logic [31:0] o_if_rdata, o_mem_rdata, o_bus_addr, o_bus_wdata;

   typedef struct {
      logic        is_i;
      logic        chk_data;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   errors = 0, checks = 0;
   logic [31:0] last_i;

   mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .i_if_valid(i_if_valid), .o_if_ready(o_if_ready), .i_if_addr(i_if_addr),
      .o_if_resp_valid(o_if_resp_valid), .o_if_rdata(o_if_rdata), .i_if_cancel(i_if_cancel),
      .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready), .i_mem_we(i_mem_we),
      .i_mem_wstrb(i_mem_wstrb), .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
      .o_mem_resp_valid(o_mem_resp_valid), .o_mem_rdata(o_mem_rdata),
      .o_bus_req(o_bus_req), .o_bus_wr(o_bus_wr), .o_bus_wstrb(o_bus_wstrb),
      .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
      .i_bus_addr_ok(i_bus_addr_ok), .i_bus_data_ok(i_bus_data_ok), .i_bus_rdata(i_bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic push(input logic is_i, input logic chk_data, input logic [31:0] data);
      exp_t e;
      e.is_i = is_i; e.chk_data = chk_data; e.data = data;
      sb.push_back(e);
   endtask

   task automatic clr_bus();
      i_bus_addr_ok = 0; i_bus_data_ok = 0; i_bus_rdata = 0;
   endtask

   // Response monitor: every pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (o_if_resp_valid || o_mem_resp_valid) begin
         if (sb.size() == 0) begin
            chk("resp_unexpected", {30'd0, o_if_resp_valid, o_mem_resp_valid}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_port", {30'd0, o_if_resp_valid, o_mem_resp_valid}, e.is_i ? 32'd2 : 32'd1);
            if (e.chk_data) chk("resp_rdata", e.is_i ? o_if_rdata : o_mem_rdata, e.data);
         end
      end
   end

   localparam logic EXP_ORDER [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   initial begin
      // Reset with both requesters valid
      i_if_valid = 1; i_if_addr = 32'h1C00_0000;
      i_mem_valid = 1; i_mem_addr = 32'h0000_0200;
      repeat (2) @(posedge clk);
      smp();
      chk("rst_bus_req", o_bus_req, 0);
      chk("rst_mem_ready", o_mem_ready, 0);
      chk("rst_rdata", o_if_rdata | o_mem_rdata, 0);
      step(); rst = 1;
      smp();
      chk("first_grant", {o_if_ready, o_mem_ready}, 2'b01);
      step(); i_mem_valid = 0; i_if_valid = 0;
      i_bus_addr_ok = 1; i_bus_data_ok = 1; i_bus_rdata = 32'hA5A5_0001; push(0, 1, 32'hA5A5_0001);
      smp();
      chk("first_req", o_bus_req, 1);
      chk("first_addr", o_bus_addr, 32'h0000_0200);
      chk("first_ready_low", {o_if_ready, o_mem_ready}, 0);
      step(); clr_bus();
      chk("sb_after_first", 32'(sb.size()), 0);
      chk("mem_rdata_held", o_mem_rdata, 32'hA5A5_0001);

      // Single I read with a 2-cycle REQ stall
      i_if_valid = 1; i_if_addr = 32'h1C00_0000;
      smp(); chk("i_ready", {o_if_ready, o_mem_ready}, 2'b10);
      step(); i_if_valid = 0;
      smp();
      chk("i_req", o_bus_req, 1);
      chk("i_addr", o_bus_addr, 32'h1C00_0000);
      chk("i_wr_wstrb", {o_bus_wr, o_bus_wstrb}, 0);
      step(); i_if_addr = 32'hFFFF_FFFF;
      smp(); chk("i_addr_stall", o_bus_addr, 32'h1C00_0000);
      step(); i_bus_addr_ok = 1;
      smp(); chk("i_req_aok", {o_bus_req, o_bus_addr}, {1'b1, 32'h1C00_0000});
      step(); i_bus_addr_ok = 0; i_bus_data_ok = 1; i_bus_rdata = 32'hDEAD_BEEF; push(1, 1, 32'hDEAD_BEEF);
      smp(); chk("wait_req_low", o_bus_req, 0);
      step(); clr_bus();
      smp(); chk("i_rdata_held", o_if_rdata, 32'hDEAD_BEEF);
      chk("sb_after_i", 32'(sb.size()), 0);

      // D write
      step();
      i_mem_valid = 1; i_mem_we = 1; i_mem_wstrb = 4'h3; i_mem_addr = 32'h100; i_mem_wdata = 32'h1234;
      smp(); chk("w_ready", o_mem_ready, 1);
      step(); i_mem_valid = 0; i_mem_we = 0; i_mem_wstrb = 0; i_mem_wdata = 0; i_bus_addr_ok = 1;
      smp();
      chk("w_cmd", {o_bus_req, o_bus_wr, o_bus_wstrb}, {1'b1, 1'b1, 4'h3});
      chk("w_addr", o_bus_addr, 32'h100);
      chk("w_wdata", o_bus_wdata, 32'h1234);
      step(); i_bus_addr_ok = 0; i_bus_data_ok = 1; push(0, 0, 0);
      step(); clr_bus();
      chk("sb_after_w", 32'(sb.size()), 0);

      // Starvation: both valid continuously, D x4 then I
      i_if_valid = 1; i_if_addr = 32'h1C00_0040;
      i_mem_valid = 1; i_mem_addr = 32'h300;
      for (int k = 0; k < 10; k++) begin
         smp(); chk($sformatf("grant_%0d", k), {o_if_ready, o_mem_ready}, EXP_ORDER[k] ? 2'b10 : 2'b01);
         step(); i_bus_addr_ok = 1; i_bus_data_ok = 1; i_bus_rdata = 32'h5000_0000 + k;
         push(EXP_ORDER[k], 1, 32'h5000_0000 + k);
         if (EXP_ORDER[k]) last_i = 32'h5000_0000 + k;
         smp(); chk($sformatf("gaddr_%0d", k), o_bus_addr, EXP_ORDER[k] ? 32'h1C00_0040 : 32'h300);
         step(); clr_bus();
      end
      i_if_valid = 0; i_mem_valid = 0;
      chk("sb_after_starve", 32'(sb.size()), 0);

      // Fetch cancelled while in WAIT
      i_if_valid = 1; i_if_addr = 32'h1C00_0080;
      smp(); chk("c_ready", o_if_ready, 1);
      step(); i_if_valid = 0; i_bus_addr_ok = 1;
      step(); i_bus_addr_ok = 0; i_if_cancel = 1;
      smp(); chk("c_wait", o_bus_req, 0);
      step(); i_if_cancel = 0; i_bus_data_ok = 1; i_bus_rdata = 32'h0BAD_F00D;
      i_mem_valid = 1; i_mem_addr = 32'h400;
      smp();
      chk("c_no_resp", o_if_resp_valid, 0);
      chk("c_mem_wait", o_mem_ready, 0);
      step(); clr_bus();
      smp();
      chk("c_d_next", o_mem_ready, 1);
      chk("c_if_rdata", o_if_rdata, last_i);
      step(); i_mem_valid = 0; i_bus_addr_ok = 1; i_bus_data_ok = 1; i_bus_rdata = 32'h1234_0400;
      push(0, 1, 32'h1234_0400);
      smp(); chk("c_d_addr", o_bus_addr, 32'h400);
      step(); clr_bus();
      chk("sb_after_cancel", 32'(sb.size()), 0);

      // Spurious data_ok in IDLE
      i_bus_data_ok = 1; i_bus_rdata = 32'h7777_7777;
      smp(); chk("spur_resp", {o_if_resp_valid, o_mem_resp_valid}, 0);
      step(); clr_bus();
      chk("spur_rdata", o_mem_rdata, 32'h1234_0400);

      // Reset asserted mid-WAIT while data_ok is arriving
      i_mem_valid = 1; i_mem_addr = 32'h500;
      step(); i_mem_valid = 0; i_bus_addr_ok = 1;
      step(); i_bus_addr_ok = 0; i_bus_data_ok = 1; i_bus_rdata = 32'h9999_9999;
      #1 rst = 0;
      #1;
      chk("rstw_req_resp", {o_bus_req, o_if_resp_valid, o_mem_resp_valid}, 0);
      chk("rstw_rdata", o_mem_rdata, 0);
      step(); step(); rst = 1;
      smp(); chk("rstw_no_stale", {o_if_resp_valid, o_mem_resp_valid}, 0);
      step(); clr_bus();
      chk("sb_final", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
